// File: rtl/lfsr_loopback_selftest.sv
// rtl/lfsr_loopback_selftest.sv - LFSR word stream through a stalled FIFO, checked against a twin LFSR
module lfsr_loopback_selftest #(
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    FIFO_DEPTH_LOG2 = 3,
    parameter int                    NUM_WORDS       = 256,
    parameter logic [DATA_WIDTH-1:0] SEED            = 16'hACE1,
    parameter int                    INJECT_ERROR_AT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       done,
    output logic                       error,
    output logic [15:0]                word_count,
    output logic [15:0]                err_count,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam int                    AW      = FIFO_DEPTH_LOG2;
    localparam int                    DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam logic [AW:0]           DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]           PTR_ONE = (AW + 1)'(1);
    localparam logic [15:0]           NW16    = 16'(NUM_WORDS);
    localparam logic [15:0]           INJ16   = 16'(INJECT_ERROR_AT);
    localparam logic                  INJ_EN  = (INJECT_ERROR_AT != 0);
    localparam logic [DATA_WIDTH-1:0] POLY    = 'hB400;

    logic [7:0]            stall_q, stall_d;
    logic [DATA_WIDTH-1:0] gen_q, gen_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic [15:0]           sent_q, sent_d;
    logic [15:0]           wc_q, wc_d;
    logic [15:0]           ec_q, ec_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  src_en;
    logic                  sink_en;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  mismatch;
    logic                  inject;
    logic [AW:0]           level;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? POLY : '0);
    endfunction

    // Handshake and datapath decode; pointers carry an extra MSB so full and empty differ.
    always_comb begin
        level      = wr_ptr_q - rd_ptr_q;
        full       = (level == DEPTH_L);
        empty      = (level == '0);
        src_en     = ~stall_q[0];
        sink_en    = ~stall_q[1];
        push       = src_en && !full && (sent_q < NW16) && !done_q;
        pop        = sink_en && !empty && !done_q;
        inject     = INJ_EN && (sent_q == INJ16);
        fifo_wdata = {gen_q[DATA_WIDTH-1:1], gen_q[0] ^ inject};
        fifo_rdata = mem[rd_ptr_q[AW-1:0]];
        mismatch   = pop && (fifo_rdata != chk_q);
    end

    always_comb begin
        stall_d  = {stall_q[6:0], stall_q[7] ^ stall_q[5] ^ stall_q[4] ^ stall_q[3]};
        gen_d    = gen_q;
        sent_d   = sent_q;
        wr_ptr_d = wr_ptr_q;
        chk_d    = chk_q;
        wc_d     = wc_q;
        rd_ptr_d = rd_ptr_q;
        ec_d     = ec_q;
        err_d    = err_q | mismatch;
        done_d   = done_q;
        if (push) begin
            gen_d    = lfsr_next(gen_q);
            sent_d   = sent_q + 16'd1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            chk_d    = lfsr_next(chk_q);
            wc_d     = wc_q + 16'd1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wc_q + 16'd1 == NW16) begin
                done_d = 1'b1;
            end
        end
        if (mismatch && (ec_q != 16'hFFFF)) begin
            ec_d = ec_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= 8'h01;
            gen_q    <= SEED;
            chk_q    <= SEED;
            sent_q   <= '0;
            wc_q     <= '0;
            ec_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            stall_q  <= stall_d;
            gen_q    <= gen_d;
            chk_q    <= chk_d;
            sent_q   <= sent_d;
            wc_q     <= wc_d;
            ec_q     <= ec_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= fifo_wdata;
        end
    end

    assign done       = done_q;
    assign error      = err_q;
    assign word_count = wc_q;
    assign err_count  = ec_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_lfsr_loopback_selftest.sv
// tb/tb_lfsr_loopback_selftest.sv - table-driven bench for lfsr_loopback_selftest
module tb_lfsr_loopback_selftest;

    localparam int F_DONE = 0;
    localparam int F_ERR  = 1;
    localparam int F_WC   = 2;
    localparam int F_EC   = 3;
    localparam int F_LVL  = 4;

    typedef struct {
        int          phase;
        int          inst;
        int          fld;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_i, rst_s;

    logic        d_done, d_error;
    logic [15:0] d_wc, d_ec;
    logic [3:0]  d_lvl;
    logic        i_done, i_error;
    logic [15:0] i_wc, i_ec;
    logic [3:0]  i_lvl;
    logic        s_done, s_error;
    logic [15:0] s_wc, s_ec;
    logic [1:0]  s_lvl;

    lfsr_loopback_selftest u_dflt (
        .clk(clk), .reset(rst_d), .done(d_done), .error(d_error),
        .word_count(d_wc), .err_count(d_ec), .fifo_level(d_lvl)
    );

    lfsr_loopback_selftest #(.INJECT_ERROR_AT(5)) u_inj (
        .clk(clk), .reset(rst_i), .done(i_done), .error(i_error),
        .word_count(i_wc), .err_count(i_ec), .fifo_level(i_lvl)
    );

    lfsr_loopback_selftest #(.FIFO_DEPTH_LOG2(1), .NUM_WORDS(1)) u_small (
        .clk(clk), .reset(rst_s), .done(s_done), .error(s_error),
        .word_count(s_wc), .err_count(s_ec), .fifo_level(s_lvl)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input int ph, input int inst, input int fld, input logic [31:0] exp, input string name);
        vec_t v;
        v.phase = ph; v.inst = inst; v.fld = fld; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] get_field(input int inst, input int fld);
        logic [4:0][31:0] f;
        case (inst)
            0:       f = {32'(d_lvl), 32'(d_ec), 32'(d_wc), 32'(d_error), 32'(d_done)};
            1:       f = {32'(i_lvl), 32'(i_ec), 32'(i_wc), 32'(i_error), 32'(i_done)};
            default: f = {32'(s_lvl), 32'(s_ec), 32'(s_wc), 32'(s_error), 32'(s_done)};
        endcase
        return f[fld];
    endfunction

    task automatic run_phase(input int ph, input int only);
        foreach (tbl[i]) begin
            if (tbl[i].phase == ph && (only < 0 || tbl[i].inst == only)) begin
                chk($sformatf("p%0d_%s_i%0d", ph, tbl[i].name, tbl[i].inst),
                    get_field(tbl[i].inst, tbl[i].fld), tbl[i].exp);
            end
        end
    endtask

    // Behavioural model of the default instance: stall LFSR, occupancy, counters.
    logic [7:0] m_stall;
    int m_level, m_sent, m_wc;
    logic m_done;
    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) begin
            m_stall = 8'h01; m_level = 0; m_sent = 0; m_wc = 0; m_done = 1'b0;
        end else begin
            logic p, q;
            p = !m_stall[0] && (m_level != 8) && (m_sent < 256) && !m_done;
            q = !m_stall[1] && (m_level != 0) && !m_done;
            if (p) begin m_level++; m_sent++; end
            if (q) begin
                m_level--; m_wc++;
                if (m_wc == 256) m_done = 1'b1;
            end
            m_stall = {m_stall[6:0], m_stall[7] ^ m_stall[5] ^ m_stall[4] ^ m_stall[3]};
        end
    end

    int trace_bad = 0;
    always @(negedge clk) begin
        if (rst_d && ((32'(d_lvl) != m_level) || (32'(d_wc) != m_wc) || (d_done !== m_done)))
            trace_bad++;
    end

    logic [15:0] g_exp;
    logic [15:0] first_w [2];
    int n_pushed;
    int stream_bad = 0;
    always @(negedge clk) begin
        if (!rst_d) begin
            n_pushed = 0; g_exp = 16'hACE1; first_w[0] = '0; first_w[1] = '0;
        end else if (u_dflt.push) begin
            if (n_pushed < 2) first_w[n_pushed] = u_dflt.fifo_wdata;
            if (u_dflt.fifo_wdata !== g_exp) stream_bad++;
            g_exp = (g_exp >> 1) ^ (g_exp[0] ? 16'hB400 : 16'h0000);
            n_pushed++;
        end
    end

    int inj_bad = 0;
    always @(negedge clk) begin
        if (rst_i && ((i_error !== (i_wc >= 16'd6)) || (i_ec !== ((i_wc >= 16'd6) ? 16'd1 : 16'd0))))
            inj_bad++;
    end

    int s_max = 0;
    always @(negedge clk) begin
        if (rst_s && (int'(s_lvl) > s_max)) s_max = int'(s_lvl);
    end

    initial begin
        int hold_bad;
        int cyc;

        for (int inst = 0; inst < 3; inst++) begin
            add(0, inst, F_DONE, 0, "done"); add(0, inst, F_ERR, 0, "error");
            add(0, inst, F_WC, 0, "wc");     add(0, inst, F_EC, 0, "ec");
            add(0, inst, F_LVL, 0, "level");
        end
        add(1, 0, F_DONE, 1, "done"); add(1, 0, F_ERR, 0, "error"); add(1, 0, F_WC, 256, "wc");
        add(1, 0, F_EC, 0, "ec");     add(1, 0, F_LVL, 0, "level");
        add(2, 1, F_DONE, 1, "done"); add(2, 1, F_ERR, 1, "error"); add(2, 1, F_WC, 256, "wc");
        add(2, 1, F_EC, 1, "ec");
        add(3, 2, F_DONE, 1, "done"); add(3, 2, F_ERR, 0, "error"); add(3, 2, F_WC, 1, "wc");
        add(3, 2, F_EC, 0, "ec");     add(3, 2, F_LVL, 0, "level");

        rst_d = 1'b0; rst_i = 1'b0; rst_s = 1'b0;
        hold_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({d_done, d_error, d_wc, d_ec, d_lvl} != '0) hold_bad++;
        end
        chk("reset_hold", 32'(hold_bad), 0);
        run_phase(0, -1);

        @(posedge clk); #2;
        rst_d = 1'b1; rst_i = 1'b1; rst_s = 1'b1;
        repeat (2000) @(negedge clk);
        run_phase(1, 0);
        run_phase(2, 1);
        run_phase(3, 2);
        chk("first_word", 32'(first_w[0]), 32'h0000ACE1);
        chk("second_word", 32'(first_w[1]), 32'h0000E270);
        chk("trace_run1", 32'(trace_bad), 0);
        chk("stream_run1", 32'(stream_bad), 0);
        chk("inj_err_timing", 32'(inj_bad), 0);
        chk("small_level_max_le2", 32'(s_max <= 2), 1);

        @(posedge clk); #2 rst_d = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_d = 1'b1;
        for (cyc = 0; cyc < 2000 && d_wc < 16'd100; cyc++) @(negedge clk);
        chk("reach_wc100", 32'(d_wc >= 16'd100), 1);
        @(posedge clk); #2 rst_d = 1'b0;
        #1 run_phase(0, 0);
        @(posedge clk); #2 rst_d = 1'b1;
        repeat (2000) @(negedge clk);
        run_phase(1, 0);
        chk("restart_first_word", 32'(first_w[0]), 32'h0000ACE1);
        chk("restart_second_word", 32'(first_w[1]), 32'h0000E270);
        chk("trace_all", 32'(trace_bad), 0);
        chk("stream_all", 32'(stream_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
